hazard_scoreboard: RTL and testbench

- Sequential hazard/stall unit for the pipelined MIPS core; replaces per-opcode combinational stall equations with a per-register Tnew countdown scoreboard.
- Decode supplies each instruction's source registers with their Tuse, and its destination register with its Tnew.
- The block stalls D while any source's pending result arrives later than that source needs it.
- It also tracks a multi-cycle mult/div unit and stalls HI/LO users while that unit is busy.

---
 rtl/hazard_scoreboard.sv | 84 ++++++++
 tb/tb_hazard_scoreboard.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register Tnew countdown scoreboard for the D-stage hazard/stall decision,
// plus a busy counter for the multi-cycle mult/div unit.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 2,
    parameter int NSRC   = 2,
    parameter int MD_LAT = 5,
    parameter int MD_CW  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     d_valid,
    input  logic [NSRC-1:0]          d_src_valid,
    input  logic [NSRC*REG_AW-1:0]   d_src_addr,
    input  logic [NSRC*CNT_W-1:0]    d_src_tuse,
    input  logic                     d_dst_we,
    input  logic [REG_AW-1:0]        d_dst_addr,
    input  logic [CNT_W-1:0]         d_tnew,
    input  logic                     d_md_start,
    input  logic                     d_md_use,
    input  logic                     flush,
    output logic                     stall,
    output logic                     stall_md,
    output logic                     md_busy,
    output logic [2**REG_AW-1:0]     pend_vec
);

    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [MD_CW-1:0]           md_cnt;
    logic [NSRC-1:0]            src_hit;
    logic                       issue;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [REG_AW-1:0] addr;
        logic [CNT_W-1:0]  tuse;
        assign addr       = d_src_addr[i*REG_AW +: REG_AW];
        assign tuse       = d_src_tuse[i*CNT_W +: CNT_W];
        // Hazard only when the pending result lands later than this source needs it.
        assign src_hit[i] = d_valid & d_src_valid[i] & (addr != '0) & (cnt[addr] > tuse);
    end

    assign stall_md = d_valid & d_md_use & (md_cnt != '0);
    assign stall    = (|src_hit) | stall_md;
    assign issue    = d_valid & ~stall & ~flush;
    assign md_busy  = (md_cnt != '0);

    always_comb begin
        pend_vec = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            pend_vec[r] = (cnt[r] != '0);
        end
    end

    // Register 0 is never loaded, so its counter stays at zero from reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else if (issue && d_dst_we && (d_dst_addr == REG_AW'(r)) && (r != 0)) begin
                    cnt[r] <= d_tnew;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // The mult/div unit runs to completion, so flush leaves this counter alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (issue && d_md_start) begin
            md_cnt <= MD_CW'(MD_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic
// checked against an absolute-ready-time model of the register and mult/div hazards.
module tb_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;
    localparam int NSRC   = 2;
    localparam int MD_LAT = 5;
    localparam int MD_CW  = 3;
    localparam int NREG   = 2**REG_AW;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   d_valid = 1'b0;
    logic [NSRC-1:0]        d_src_valid = '0;
    logic [NSRC*REG_AW-1:0] d_src_addr = '0;
    logic [NSRC*CNT_W-1:0]  d_src_tuse = '0;
    logic                   d_dst_we = 1'b0;
    logic [REG_AW-1:0]      d_dst_addr = '0;
    logic [CNT_W-1:0]       d_tnew = '0;
    logic                   d_md_start = 1'b0;
    logic                   d_md_use = 1'b0;
    logic                   flush = 1'b0;
    logic                   stall, stall_md, md_busy;
    logic [NREG-1:0]        pend_vec;

    int checks = 0;
    int failures = 0;

    hazard_scoreboard #(
        .REG_AW(REG_AW), .CNT_W(CNT_W), .NSRC(NSRC), .MD_LAT(MD_LAT), .MD_CW(MD_CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_src_valid(d_src_valid),
        .d_src_addr(d_src_addr), .d_src_tuse(d_src_tuse), .d_dst_we(d_dst_we),
        .d_dst_addr(d_dst_addr), .d_tnew(d_tnew), .d_md_start(d_md_start),
        .d_md_use(d_md_use), .flush(flush), .stall(stall), .stall_md(stall_md),
        .md_busy(md_busy), .pend_vec(pend_vec)
    );

    always #5 clk = ~clk;

    // Model: each register remembers the absolute cycle its result becomes forwardable.
    int cyc = 0;
    int ready [NREG];
    int md_done = 0;

    function automatic int rem(input int r);
        if (r == 0) return 0;
        return (ready[r] > cyc) ? ready[r] - cyc : 0;
    endfunction

    function automatic bit m_stall_md();
        return d_valid && d_md_use && (md_done > cyc);
    endfunction

    function automatic bit m_stall();
        bit s;
        int a, t;
        s = m_stall_md();
        for (int i = 0; i < NSRC; i++) begin
            a = int'(d_src_addr[i*REG_AW +: REG_AW]);
            t = int'(d_src_tuse[i*CNT_W +: CNT_W]);
            if (d_valid && d_src_valid[i] && rem(a) > t) s = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [NREG-1:0] m_pend();
        logic [NREG-1:0] v;
        v = '0;
        for (int r = 0; r < NREG; r++) v[r] = (rem(r) > 0);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) ready[r] <= 0;
            md_done <= 0;
        end else begin
            if (flush) begin
                for (int r = 0; r < NREG; r++) ready[r] <= 0;
            end else if (d_valid && !m_stall() && d_dst_we && d_dst_addr != 0) begin
                ready[d_dst_addr] <= cyc + 1 + int'(d_tnew);
            end
            if (d_valid && !m_stall() && !flush && d_md_start) md_done <= cyc + 1 + MD_LAT;
            cyc <= cyc + 1;
        end
    end

    task automatic drive(input bit v, input bit [1:0] sv, input int a0, input int a1,
                         input int t0, input int t1, input bit we, input int dst,
                         input int tnew, input bit ms, input bit mu, input bit fl);
        d_valid     = v;
        d_src_valid = sv;
        d_src_addr  = {REG_AW'(a1), REG_AW'(a0)};
        d_src_tuse  = {CNT_W'(t1), CNT_W'(t0)};
        d_dst_we    = we;
        d_dst_addr  = REG_AW'(dst);
        d_tnew      = CNT_W'(tnew);
        d_md_start  = ms;
        d_md_use    = mu;
        flush       = fl;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        drive(1, 2'b11, 1, 2, 0, 0, 1, 3, 2, 1, 1, 0);
        #2;
        checks++;
        if ({stall, stall_md, md_busy} !== 3'b000 || pend_vec !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%h exp=000/0", {stall, stall_md, md_busy}, pend_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
        @(negedge clk); drive(1, 2'b01, 8, 0, 1, 0, 1, 10, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b1 || pend_vec[8] !== 1'b1) begin
            failures++; $display("FAIL load_use_c1 stall=%b pend8=%b exp=1,1", stall, pend_vec[8]);
        end
        @(negedge clk); #1;
        checks++;
        if (stall !== 1'b0 || pend_vec[8] !== 1'b1) begin
            failures++; $display("FAIL load_use_c2 stall=%b pend8=%b exp=0,1", stall, pend_vec[8]);
        end
        @(negedge clk); drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (pend_vec[8] !== 1'b0 || pend_vec[10] !== 1'b1) begin
            failures++; $display("FAIL load_use_c3 pend8=%b pend10=%b exp=0,1", pend_vec[8], pend_vec[10]);
        end
        idle(4);
    endtask

    task automatic test_branch();
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        @(negedge clk); drive(1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL branch_stall got=%b exp=1", stall); end
        @(negedge clk); #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL branch_release got=%b exp=0", stall); end
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        @(negedge clk); drive(1, 2'b11, 9, 29, 2, 1, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL store_data_stall got=%b exp=0", stall); end
        idle(4);
    endtask

    task automatic test_reg_zero();
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
        @(negedge clk); drive(1, 2'b11, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0); #1;
        checks++;
        if (stall !== 1'b0 || pend_vec[3:0] !== 4'b0000 || pend_vec[0] !== 1'b0) begin
            failures++; $display("FAIL reg_zero stall=%b pend=%h exp=0,0", stall, pend_vec);
        end
        idle(4);
    endtask

    task automatic test_overwrite();
        // Spec case lw tnew=2 then ori tnew=1; then lw tnew=3 then ori tnew=1 to separate load from decrement.
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0);
        @(negedge clk); drive(1, 2'b01, 4, 0, 1, 0, 1, 5, 1, 0, 0, 0);
        @(negedge clk); drive(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (pend_vec[5] !== 1'b1 || stall !== 1'b1) begin
            failures++; $display("FAIL overwrite_a pend5=%b stall=%b exp=1,1", pend_vec[5], stall);
        end
        idle(4);
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 5, 3, 0, 0, 0);
        @(negedge clk); drive(1, 2'b01, 4, 0, 1, 0, 1, 5, 1, 0, 0, 0); #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL overwrite_issue got=%b exp=0", stall); end
        @(negedge clk); drive(1, 2'b01, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (pend_vec[5] !== 1'b1 || stall !== 1'b0) begin
            failures++; $display("FAIL overwrite_b pend5=%b stall=%b exp=1,0", pend_vec[5], stall);
        end
        idle(4);
    endtask

    task automatic test_md(input bit with_flush);
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL md_start_stall got=%b exp=0", stall); end
        for (int k = 0; k < MD_LAT; k++) begin
            @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 12, 1, 0, 1, with_flush && k == 1); #1;
            checks++;
            if ({stall, stall_md, md_busy} !== 3'b111) begin
                failures++;
                $display("FAIL md_busy_cycle%0d flush=%0b got=%b exp=111", k, with_flush, {stall, stall_md, md_busy});
            end
        end
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 12, 1, 0, 1, 0); #1;
        checks++;
        if ({stall, stall_md, md_busy} !== 3'b000) begin
            failures++; $display("FAIL md_release got=%b exp=000", {stall, stall_md, md_busy});
        end
        idle(6);
    endtask

    task automatic test_flush();
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0);
        @(negedge clk); drive(1, 2'b01, 3, 0, 0, 0, 1, 6, 1, 0, 0, 1); #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL flush_pre_stall got=%b exp=1", stall); end
        @(negedge clk); flush = 1'b0; #1;
        checks++;
        if (stall !== 1'b0 || pend_vec !== '0) begin
            failures++; $display("FAIL flush_clear stall=%b pend=%h exp=0,0", stall, pend_vec);
        end
        idle(4);
    endtask

    task automatic test_async_reset();
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0);
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        @(negedge clk); drive(1, 2'b01, 3, 0, 0, 0, 1, 7, 1, 0, 1, 0); #1;
        checks++;
        if ({stall, stall_md, md_busy} !== 3'b111 || pend_vec[3] !== 1'b1) begin
            failures++; $display("FAIL rst_pre got=%b pend3=%b exp=111,1", {stall, stall_md, md_busy}, pend_vec[3]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({stall, stall_md, md_busy} !== 3'b000 || pend_vec !== '0) begin
            failures++; $display("FAIL rst_async got=%b pend=%h exp=000,0", {stall, stall_md, md_busy}, pend_vec);
        end
        #1 rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 24) == 0);
            if (d_md_start) d_md_use = 1'b1;
            #1;
            checks++;
            if (stall !== m_stall()) begin
                failures++; $display("FAIL rand_stall k=%0d got=%b exp=%b", k, stall, m_stall());
            end
            checks++;
            if (stall_md !== m_stall_md()) begin
                failures++; $display("FAIL rand_stall_md k=%0d got=%b exp=%b", k, stall_md, m_stall_md());
            end
            checks++;
            if (md_busy !== (md_done > cyc)) begin
                failures++; $display("FAIL rand_md_busy k=%0d got=%b exp=%b", k, md_busy, md_done > cyc);
            end
            checks++;
            if (pend_vec !== m_pend()) begin
                failures++; $display("FAIL rand_pend k=%0d got=%h exp=%h", k, pend_vec, m_pend());
            end
        end
        idle(6);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_reg_zero();
        test_overwrite();
        test_md(1'b0);
        test_md(1'b1);
        test_flush();
        test_async_reset();
        test_random(600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
